// File: rtl/spi_bus_arb.sv
// spi_bus_arb -- shares one SPI_mnrch master between two clients.
//   Client 0 is the A2D interface, client 1 the inertial-sensor interface.
//   One owner at a time is granted; its wrt/wdat are forwarded to the master,
//   the master's done is steered back to it, SS_n is demuxed per device and
//   MISO is muxed from the owning device. lockX keeps ownership across
//   back-to-back transfers (e.g. A2D channel-select + read pair).
//
// Optional feature macro: SPI_ARB_TMO_EN
//   defined   : an owner idling in OWN (no wrt) for TMO_CYC cycles is forcibly
//               released and tmo_err pulses for one cycle.
//   undefined : no watchdog, tmo_err tied 0.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   req0/1, lock0/1       client request / keep-bus-after-transfer
//   wrt0/1, wdat0/1       client start pulse and transmit word
//   gnt0/1                registered grant, one-hot or zero
//   done0/1               1-cycle completion pulse to owner
//   rd_data               last received word (passes through on spi_done)
//   spi_wrt, spi_wdat     to SPI_mnrch
//   spi_done, spi_rdat,
//   spi_SS_n              from SPI_mnrch
//   spi_MISO              to SPI_mnrch (muxed)
//   ss0_n/1_n, miso0/1    per-device select / MISO
//   tmo_err               forced-release pulse
module spi_bus_arb #(
  parameter int TMO_CYC = 4096,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          wrt0,
  input  logic          wrt1,
  input  logic [DW-1:0] wdat0,
  input  logic [DW-1:0] wdat1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rd_data,
  output logic          spi_wrt,
  output logic [DW-1:0] spi_wdat,
  input  logic          spi_done,
  input  logic [DW-1:0] spi_rdat,
  input  logic          spi_SS_n,
  output logic          spi_MISO,
  output logic          ss0_n,
  output logic          ss1_n,
  input  logic          miso0,
  input  logic          miso1,
  output logic          tmo_err
);

  // Watchdog counter is 12 bits wide, so TMO_CYC must lie in 2..4096.
  if (TMO_CYC < 2 || TMO_CYC > 4096) begin : g_tmo_range_bad
    $error("spi_bus_arb: TMO_CYC out of range");
  end

  typedef enum logic [1:0] {IDLE, OWN, XFER} state_t;

  state_t        state, state_nxt;
  logic          own, own_nxt;
  logic          prio, prio_nxt;
  logic          gnt0_nxt, gnt1_nxt;
  logic [DW-1:0] rd_q;
  logic          req_o, wrt_o, lock_o, gnt_o;
  logic          tmo_hit;

  // Owner-selected views of the client signals
  assign req_o  = own ? req1  : req0;
  assign wrt_o  = own ? wrt1  : wrt0;
  assign lock_o = own ? lock1 : lock0;
  assign gnt_o  = gnt0 | gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      own   <= 1'b0;
      prio  <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      rd_q  <= '0;
    end else begin
      state <= state_nxt;
      own   <= own_nxt;
      prio  <= prio_nxt;
      gnt0  <= gnt0_nxt;
      gnt1  <= gnt1_nxt;
      if (state == XFER && spi_done) rd_q <= spi_rdat;
    end
  end

  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    prio_nxt  = prio;
    gnt0_nxt  = gnt0;
    gnt1_nxt  = gnt1;
    spi_wrt   = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          // Sole requester wins; on a tie prio picks the owner.
          own_nxt   = (req0 & req1) ? prio : req1;
          gnt0_nxt  = ~own_nxt;
          gnt1_nxt  = own_nxt;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (wrt_o && gnt_o) begin
          spi_wrt   = 1'b1;
          state_nxt = XFER;
        end else if (!req_o || tmo_hit) begin
          gnt0_nxt  = 1'b0;
          gnt1_nxt  = 1'b0;
          prio_nxt  = ~own;
          state_nxt = IDLE;
        end
      end
      XFER: begin
        // Completes even if the owner dropped req meanwhile.
        if (spi_done) begin
          done0 = ~own;
          done1 = own;
          if (lock_o) begin
            state_nxt = OWN;
          end else begin
            gnt0_nxt  = 1'b0;
            gnt1_nxt  = 1'b0;
            prio_nxt  = ~own;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
      end
    endcase
  end

  assign rd_data  = (state == XFER && spi_done) ? spi_rdat : rd_q;
  assign spi_wdat = gnt1 ? wdat1 : (gnt0 ? wdat0 : '0);
  assign ss0_n    = spi_SS_n | ~gnt0;
  assign ss1_n    = spi_SS_n | ~gnt1;
  assign spi_MISO = gnt1 ? miso1 : miso0;

`ifdef SPI_ARB_TMO_EN
  localparam logic [11:0] TMO_LAST = 12'(TMO_CYC - 1);

  logic [11:0] tmo_cnt;
  logic        tmo_q;

  assign tmo_hit = (state == OWN) && (tmo_cnt == TMO_LAST);

  // Counter sits at 0 outside OWN, so entering OWN (from IDLE or a locked
  // XFER) always starts a fresh window; a wrt also restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= (state == OWN) && !(wrt_o && gnt_o) && req_o && tmo_hit;
      if (state != OWN || spi_wrt) tmo_cnt <= '0;
      else                         tmo_cnt <= tmo_cnt + 12'd1;
    end
  end

  assign tmo_err = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_bus_arb.sv
// Directed bench for spi_bus_arb. Inputs change 1 time unit after posedge;
// outputs are checked before the next posedge. The SPI master is emulated
// by driving spi_done / spi_rdat / spi_SS_n directly.
module tb_spi_bus_arb;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, lock0, lock1, wrt0, wrt1;
  logic [DW-1:0] wdat0, wdat1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rd_data;
  logic          spi_wrt;
  logic [DW-1:0] spi_wdat;
  logic          spi_done;
  logic [DW-1:0] spi_rdat;
  logic          spi_SS_n, spi_MISO;
  logic          ss0_n, ss1_n, miso0, miso1;
  logic          tmo_err;

  int n_cmp = 0;
  int n_bad = 0;

  spi_bus_arb #(.TMO_CYC(16), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .wrt0(wrt0), .wrt1(wrt1), .wdat0(wdat0), .wdat1(wdat1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rd_data(rd_data), .spi_wrt(spi_wrt), .spi_wdat(spi_wdat),
    .spi_done(spi_done), .spi_rdat(spi_rdat), .spi_SS_n(spi_SS_n),
    .spi_MISO(spi_MISO), .ss0_n(ss0_n), .ss1_n(ss1_n),
    .miso0(miso0), .miso1(miso1), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; wrt0 = 0; wrt1 = 0;
    wdat0 = '0; wdat1 = '0; spi_done = 0; spi_rdat = '0; spi_SS_n = 1;
    miso0 = 0; miso1 = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    clr_inputs();
    tick();
    // ---- reset state
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_ss0", ss0_n, 1);
    chk("rst_ss1", ss1_n, 1);
    chk("rst_wrt", spi_wrt, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_tmo", tmo_err, 0);
    rst_n = 1;
    tick();

    // ---- single client transfer
    req0 = 1;
    tick();
    chk("t1_gnt0", gnt0, 1);
    chk("t1_gnt1", gnt1, 0);
    wrt0 = 1; wdat0 = 16'h2000; spi_SS_n = 0; miso0 = 1; miso1 = 0;
    #1;
    chk("t1_spi_wrt", spi_wrt, 1);
    chk("t1_spi_wdat", spi_wdat, 16'h2000);
    chk("t1_ss0", ss0_n, 0);
    chk("t1_ss1", ss1_n, 1);
    chk("t1_miso", spi_MISO, 1);
    tick();
    wrt0 = 0;
    #1;
    chk("t1_wrt_one", spi_wrt, 0);
    tick();
    spi_done = 1; spi_rdat = 16'h0ABC; req0 = 0;
    #1;
    chk("t1_done0", done0, 1);
    chk("t1_done1", done1, 0);
    chk("t1_rd_pass", rd_data, 16'h0ABC);
    tick();
    spi_done = 0; spi_SS_n = 1; spi_rdat = 16'h5555;
    #1;
    chk("t1_rel_gnt0", gnt0, 0);
    chk("t1_done_pulse", done0, 0);
    chk("t1_rd_held", rd_data, 16'h0ABC);

    // ---- simultaneous requests after reset: req0 first
    do_reset();
    req0 = 1; req1 = 1;
    tick();
    chk("t2_gnt0", gnt0, 1);
    chk("t2_gnt1", gnt1, 0);
    req0 = 0;
    tick();
    chk("t2_rel_gnt0", gnt0, 0);
    chk("t2_rel_gnt1", gnt1, 0);
    tick();
    chk("t2_next_gnt1", gnt1, 1);
    chk("t2_next_gnt0", gnt0, 0);
    req1 = 0;
    tick();
    chk("t2_idle_gnt1", gnt1, 0);

    // ---- locked pair, req1 waiting (prio back at 0)
    req0 = 1; lock0 = 1; req1 = 1;
    tick();
    chk("t3_gnt0", gnt0, 1);
    wrt0 = 1; wdat0 = 16'h1111;
    tick();
    wrt0 = 0; spi_done = 1; spi_rdat = 16'h0001;
    #1;
    chk("t3_done0_a", done0, 1);
    tick();
    spi_done = 0;
    #1;
    chk("t3_lock_gnt0", gnt0, 1);
    chk("t3_lock_gnt1", gnt1, 0);
    wrt0 = 1; wdat0 = 16'h2222;
    #1;
    chk("t3_wdat2", spi_wdat, 16'h2222);
    tick();
    wrt0 = 0; lock0 = 0; req0 = 0; spi_done = 1; spi_rdat = 16'h0002;
    #1;
    chk("t3_done0_b", done0, 1);
    chk("t3_rd_b", rd_data, 16'h0002);
    chk("t3_wait_gnt1", gnt1, 0);
    tick();
    spi_done = 0;
    #1;
    chk("t3_rel_gnt1", gnt1, 0);
    tick();
    chk("t3_gnt1", gnt1, 1);

    // ---- non-owner wrt ignored; spi_done outside XFER ignored
    req1 = 0;
    tick();
    req0 = 1;
    tick();
    chk("t4_gnt0", gnt0, 1);
    wdat0 = 16'h3333; wrt1 = 1; wdat1 = 16'h4444;
    #1;
    chk("t4_spi_wrt", spi_wrt, 0);
    chk("t4_spi_wdat", spi_wdat, 16'h3333);
    tick();
    chk("t4_still_own", gnt0, 1);
    spi_done = 1; spi_rdat = 16'h7777;
    #1;
    chk("t4_no_done1", done1, 0);
    chk("t4_no_done0", done0, 0);
    chk("t4_rd_kept", rd_data, 16'h0002);
    wrt1 = 0; spi_done = 0;

    // ---- reset mid-transfer
    wrt0 = 1;
    tick();
    wrt0 = 0; spi_SS_n = 0;
    #1;
    chk("t6_pre_ss0", ss0_n, 0);
    rst_n = 0;
    #1;
    chk("t6_gnt0", gnt0, 0);
    chk("t6_ss0", ss0_n, 1);
    chk("t6_ss1", ss1_n, 1);
    chk("t6_wrt", spi_wrt, 0);
    tick();
    rst_n = 1; req0 = 0; spi_done = 1; spi_rdat = 16'h9999;
    #1;
    chk("t6_no_done", done0, 0);
    chk("t6_rd0", rd_data, 0);
    tick();
    chk("t6_rd0_b", rd_data, 0);
    chk("t6_idle", gnt0, 0);
    spi_done = 0; spi_SS_n = 1;

    // ---- idle owner watchdog
    do_reset();
    req0 = 1;
    tick();
    chk("t5_gnt0", gnt0, 1);
    req1 = 1;
    repeat (15) tick();
    chk("t5_hold_gnt0", gnt0, 1);
    chk("t5_no_tmo", tmo_err, 0);
    tick();
`ifdef SPI_ARB_TMO_EN
    chk("t5_tmo_err", tmo_err, 1);
    chk("t5_drop_gnt0", gnt0, 0);
    tick();
    chk("t5_tmo_pulse", tmo_err, 0);
    chk("t5_gnt1", gnt1, 1);
    chk("t5_gnt0_off", gnt0, 0);
`else
    repeat (8) tick();
    chk("t5_nt_gnt0", gnt0, 1);
    chk("t5_nt_tmo", tmo_err, 0);
    chk("t5_nt_gnt1", gnt1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
